fir_decimator: RTL and testbench

Integrate-and-dump decimator directly downstream of the fir filter. Consumes the filter output stream y, sums DECIM consecutive valid samples and divides by DECIM with an arithmetic shift. Buffers the decimated results in a small first-word-fall-through FIFO. Presents the results on a valid/ready interface to the next stage.

---
 rtl/fir_decimator.sv | 115 +++++++++++
 tb/tb_fir_decimator.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator: averages DECIM valid samples by sum and arithmetic shift,
// then buffers each mean in a small first-word-fall-through FIFO behind a valid/ready port.
module fir_decimator #(
  parameter int DATA_W = 16,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic signed [DATA_W-1:0]  y_in,
  input  logic                      y_valid,
  output logic signed [DATA_W-1:0]  out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  localparam int SH    = $clog2(DECIM);
  localparam int ACC_W = DATA_W + SH;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam logic [SH-1:0] LAST = SH'(DECIM - 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  // Floor division by DECIM; the mean of DATA_W-bit samples always fits in DATA_W bits.
  function automatic logic signed [DATA_W-1:0] mean_f(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] q;
    q = s >>> SH;
    return q[DATA_W-1:0];
  endfunction

  logic [SH-1:0]             phase_q, phase_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [AW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]             level_q, level_d;
  logic                      ovf_q, ovf_d;
  logic signed [DATA_W-1:0]  mem_q [DEPTH];

  logic signed [ACC_W-1:0]   ext, sum;
  logic signed [DATA_W-1:0]  res;
  logic                      push, pop, full, wr_en;

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rptr_q] : '0;
  assign level     = level_q;
  assign overflow  = ovf_q;

  assign ext  = {{SH{y_in[DATA_W-1]}}, y_in};
  assign sum  = (phase_q == '0) ? ext : acc_q + ext;
  assign res  = mean_f(sum);
  assign full = (level_q == FULL);

  always_comb begin
    phase_d = phase_q;
    acc_d   = acc_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    pop     = 1'b0;
    wr_en   = 1'b0;
    if (clear) begin
      phase_d = '0;
      acc_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
    end else begin
      push = y_valid && (phase_q == LAST);
      pop  = out_valid && out_ready;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      wr_en = push && (!full || pop);
      if (y_valid) begin
        phase_d = phase_q + 1'b1;
        acc_d   = sum;
      end
      if (push && !wr_en) ovf_d = 1'b1;
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (pop)   rptr_d = rptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      acc_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      acc_q   <= acc_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: out_data is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wptr_q] <= res;
  end

endmodule

// File: tb/tb_fir_decimator.sv
// Bench for fir_decimator: directed vectors, expected results queued by the driver
// and compared by a monitor whenever the DUT hands over a result.
module tb_fir_decimator;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               clear = 1'b0;
  logic signed [15:0] y_in = '0;
  logic               y_valid = 1'b0;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [2:0]         level;
  logic               overflow;

  int total = 0;
  int passed = 0;
  logic [15:0] exp_q[$];

  fir_decimator #(.DATA_W(16), .DECIM(4), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .y_in(y_in), .y_valid(y_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
  endtask

  // Monitor: a handshake seen mid-cycle is a pop at the next posedge.
  always @(negedge clock) begin
    if (reset && !clear && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL pop_unexpected: got 0x%04h, expected no result", out_data);
      end else begin
        chk("pop_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic signed [15:0] v);
    y_in = v;
    y_valid = 1'b1;
    tick();
  endtask

  task automatic idle();
    y_valid = 1'b0;
  endtask

  task automatic block4(input logic signed [15:0] a, b, c, d, input logic [15:0] e, input string name);
    exp_q.push_back(e);
    send(a); send(b); send(c); send(d);
    idle();
    chk({name, "_valid"}, {15'd0, out_valid}, 16'd1);
    chk({name, "_data"}, out_data, e);
  endtask

  initial begin
    #2;
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_level", {13'd0, level}, 16'd0);
    chk("rst_ovf", {15'd0, overflow}, 16'd0);
    chk("rst_data", out_data, 16'd0);
    tick();
    reset = 1'b1;
    tick();

    // Basic mean and latency
    out_ready = 1'b1;
    block4(10, 9, 8, 7, 16'd8, "basic");
    chk("basic_level_pre_pop", {13'd0, level}, 16'd1);
    tick();
    chk("basic_level_post_pop", {13'd0, level}, 16'd0);

    // Rounding toward minus infinity and extremes
    block4(-1, -1, -1, -2, 16'hFFFE, "neg_round");
    block4(32767, 32767, 32767, 32767, 16'h7FFF, "max");
    block4(-32768, -32768, -32768, -32768, 16'h8000, "min");
    tick();

    // Gaps in y_valid hold phase and accumulator
    exp_q.push_back(16'd4);
    send(4); send(4);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_no_result", {15'd0, out_valid}, 16'd0);
    end
    send(4);
    chk("gap_no_early", {15'd0, out_valid}, 16'd0);
    send(4);
    idle();
    chk("gap_valid", {15'd0, out_valid}, 16'd1);
    chk("gap_data", out_data, 16'd4);
    tick();

    // Overflow: five results into a four-deep FIFO with no drain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(16'd1);
    for (int i = 0; i < 16; i++) send(1);
    chk("ovf_level4", {13'd0, level}, 16'd4);
    chk("ovf_not_yet", {15'd0, overflow}, 16'd0);
    for (int i = 0; i < 4; i++) send(1);
    idle();
    chk("ovf_level", {13'd0, level}, 16'd4);
    chk("ovf_data", out_data, 16'd1);
    chk("ovf_flag", {15'd0, overflow}, 16'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
    chk("ovf_drained", {13'd0, level}, 16'd0);
    chk("ovf_sticky", {15'd0, overflow}, 16'd1);

    // Clear drops the sticky flag
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ovf", {15'd0, overflow}, 16'd0);
    chk("clr_level", {13'd0, level}, 16'd0);

    // Full FIFO with a pop during the fifth push
    for (int b = 1; b <= 5; b++) exp_q.push_back(16'(b * 10));
    for (int b = 1; b <= 4; b++)
      for (int i = 0; i < 4; i++) send(16'(b * 10));
    chk("full_level", {13'd0, level}, 16'd4);
    send(50); send(50); send(50);
    out_ready = 1'b1;
    send(50);
    idle();
    out_ready = 1'b0;
    chk("full_pop_level", {13'd0, level}, 16'd4);
    chk("full_pop_ovf", {15'd0, overflow}, 16'd0);
    chk("full_pop_head", out_data, 16'd20);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("full_drained", {13'd0, level}, 16'd0);

    // Asynchronous reset mid-block discards phase and accumulator
    send(100); send(100);
    idle();
    reset = 1'b0;
    #1;
    chk("arst_valid", {15'd0, out_valid}, 16'd0);
    chk("arst_level", {13'd0, level}, 16'd0);
    chk("arst_data", out_data, 16'd0);
    #4;
    reset = 1'b1;
    tick();
    block4(10, 9, 8, 7, 16'd8, "arst_after");
    tick();
    chk("arst_single", {13'd0, level}, 16'd0);

    // Synchronous clear mid-block, with an ignored sample in the clear cycle
    send(100); send(100);
    clear = 1'b1;
    send(55);
    clear = 1'b0;
    idle();
    chk("clr_mid_level", {13'd0, level}, 16'd0);
    block4(10, 9, 8, 7, 16'd8, "clr_after");
    tick();
    chk("clr_single", {13'd0, level}, 16'd0);

    tick(); tick();
    chk("leftover", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
